// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver
//   Scan driver for a 32x32 HUB75 panel with 1/16 multiplexing. Two half-panels
//   are shifted in parallel from an internal 1-bit-per-colour frame buffer.
//   The next row is shifted while the current row is lit. The panel is then
//   blanked, the shifted data is latched, and the new row is selected.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   wr_en/addr/data     frame-buffer write port; addr = {row[4:0], col[4:0]},
//                       data = {r,g,b}; rows 0-15 top half, 16-31 bottom half
//   mclk                panel shift clock
//   red/green/blue_1    top-half pixel data
//   red/green/blue_2    bottom-half pixel data
//   row_sel             {d,c,b,a} scan row
//   latch               active-high latch pulse
//   output_en           panel OE, active-low (1 = blanked)
//   frame_start         one-cycle pulse on the first shift cycle of row 0
module led_matrix_scan_driver #(
  parameter int unsigned COLS    = 32,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned ON_TIME = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic [2:0] wr_data,
  output logic       mclk,
  output logic       red_1,
  output logic       green_1,
  output logic       blue_1,
  output logic       red_2,
  output logic       green_2,
  output logic       blue_2,
  output logic [3:0] row_sel,
  output logic       latch,
  output logic       output_en,
  output logic       frame_start
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PH_N  = 2 * CLK_DIV;
  localparam int unsigned PH_W  = $clog2(PH_N);
  localparam int unsigned ON_W  = $clog2(ON_TIME + 1);
  localparam int unsigned AW    = 4 + COL_W;
  localparam int unsigned DEPTH = 16 << COL_W;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    BLANK,
    LATCH
  } state_t;

  state_t          state, state_d;
  logic [PH_W-1:0] phase, phase_d;
  logic [COL_W-1:0] col, col_d;
  logic [3:0]      shift_row, shift_row_d;
  logic [ON_W-1:0] on_cnt, on_cnt_d;
  logic            lit, lit_d;
  logic            armed;
  logic            on_done, col_last, ph_last;

  // Frame buffer: one array per half-panel, indexed {row_in_half, col}.
  logic [2:0]    mem_top [DEPTH];
  logic [2:0]    mem_bot [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          rd_en;
  logic [2:0]    top_q, bot_q;

  assign wr_idx = {wr_addr[8:5], wr_addr[COL_W-1:0]};
  assign rd_idx = {shift_row, col};
  assign rd_en  = (state == SHIFT) && (phase == '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_addr[9]) mem_bot[wr_idx] <= wr_data;
      else            mem_top[wr_idx] <= wr_data;
    end
  end

  // Registered read: a read on the same edge as a write returns the old word.
  // These registers drive the colour pins directly. Their contents hold from
  // phase cycle 1 through the end of the column.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q <= '0;
      bot_q <= '0;
    end else if (rd_en) begin
      top_q <= mem_top[rd_idx];
      bot_q <= mem_bot[rd_idx];
    end
  end

  assign {red_1, green_1, blue_1} = top_q;
  assign {red_2, green_2, blue_2} = bot_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= '0;
      col       <= '0;
      shift_row <= '0;
      on_cnt    <= '0;
      lit       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      col       <= col_d;
      shift_row <= shift_row_d;
      on_cnt    <= on_cnt_d;
      lit       <= lit_d;
      armed     <= 1'b1;
    end
  end

  // The threshold is ON_TIME-1 because this test runs in the last lit cycle.
  // That row has then been lit for exactly ON_TIME cycles when BLANK begins.
  assign on_done  = (on_cnt >= ON_W'(ON_TIME - 1));
  assign col_last = (col == COL_W'(COLS - 1));
  assign ph_last  = (phase == PH_W'(PH_N - 1));

  always_comb begin
    state_d     = state;
    phase_d     = phase;
    col_d       = col;
    shift_row_d = shift_row;
    lit_d       = lit;
    on_cnt_d    = (on_cnt == ON_W'(ON_TIME)) ? on_cnt : on_cnt + 1'b1;

    case (state)
      IDLE: begin
        // armed delays the exit by one full cycle after reset release.
        if (armed) begin
          state_d     = SHIFT;
          phase_d     = '0;
          col_d       = '0;
          shift_row_d = '0;
        end
      end
      SHIFT: begin
        if (ph_last) begin
          phase_d = '0;
          if (col_last) begin
            col_d   = '0;
            state_d = (!lit || on_done) ? BLANK : WAIT;
          end else begin
            col_d = col + 1'b1;
          end
        end else begin
          phase_d = phase + 1'b1;
        end
      end
      WAIT: begin
        if (on_done) state_d = BLANK;
      end
      BLANK: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d     = SHIFT;
        shift_row_d = shift_row + 4'd1;
        lit_d       = 1'b1;
        on_cnt_d    = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Panel controls are registered from the next-state values. They stay
  // aligned with the state register and come straight off flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mclk        <= 1'b0;
      latch       <= 1'b0;
      output_en   <= 1'b1;
      frame_start <= 1'b0;
      row_sel     <= '0;
    end else begin
      mclk        <= (state_d == SHIFT) && (phase_d >= PH_W'(CLK_DIV));
      latch       <= (state_d == LATCH);
      output_en   <= !(lit_d && ((state_d == SHIFT) || (state_d == WAIT)));
      frame_start <= (state_d == SHIFT) && (state != SHIFT) && (shift_row_d == '0);
      if (state_d == LATCH) row_sel <= shift_row;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
module tb_led_matrix_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [2:0] wr_data = '0;

  logic       mclk, red_1, green_1, blue_1, red_2, green_2, blue_2;
  logic [3:0] row_sel;
  logic       latch, output_en, frame_start;

  logic       mclk_b, red_1_b, green_1_b, blue_1_b, red_2_b, green_2_b, blue_2_b;
  logic [3:0] row_sel_b;
  logic       latch_b, output_en_b, frame_start_b;

  led_matrix_scan_driver #(.COLS(32), .CLK_DIV(2), .ON_TIME(256)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mclk(mclk), .red_1(red_1), .green_1(green_1), .blue_1(blue_1),
    .red_2(red_2), .green_2(green_2), .blue_2(blue_2),
    .row_sel(row_sel), .latch(latch), .output_en(output_en), .frame_start(frame_start)
  );

  led_matrix_scan_driver #(.COLS(32), .CLK_DIV(2), .ON_TIME(64)) dut_short (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mclk(mclk_b), .red_1(red_1_b), .green_1(green_1_b), .blue_1(blue_1_b),
    .red_2(red_2_b), .green_2(green_2_b), .blue_2(blue_2_b),
    .row_sel(row_sel_b), .latch(latch_b), .output_en(output_en_b), .frame_start(frame_start_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int cyc, last_latch, last_fs, n_fs, n_latch, exp_row, rises, last_rise;
  int last_latch_b, n_latch_b, coll_phase;
  logic prev_mclk, prev_oe, chk_after;
  logic [3:0] prev_row_sel;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr_pix(input logic [9:0] a, input logic [2:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic restart_counters();
    cyc = 0; last_latch = 0; last_fs = 0; n_fs = 0; n_latch = 0;
    exp_row = 0; rises = 0; last_rise = 0; last_latch_b = 0; n_latch_b = 0;
    chk_after = 1'b0;
  endtask

  // Release on the cycle after a posedge. One IDLE cycle follows, and the
  // first SHIFT cycle (with frame_start) appears after the second edge.
  task automatic release_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("fs_before_edge1", frame_start, 0);
    @(negedge clk);
    chk("fs_idle", frame_start, 0);
    restart_counters();
    prev_mclk = mclk;
    prev_oe = output_en;
    prev_row_sel = row_sel;
  endtask

  task automatic sample();
    logic [2:0] top, bot;
    @(negedge clk);
    cyc++;
    wr_en = 1'b0;
    top = {red_1, green_1, blue_1};
    bot = {red_2, green_2, blue_2};

    if (cyc == 1) chk("fs_first", frame_start, 1);

    if (frame_start) begin
      if (n_fs > 0) chk("fs_period", cyc - last_fs, (n_fs == 1) ? 4000 : 4128);
      if (coll_phase == 1) coll_phase = 2;
      n_fs++;
      last_fs = cyc;
    end

    if (mclk && !prev_mclk) begin
      if (exp_row == 3) begin
        chk("row3_top", top, (rises % 2 == 0) ? 3'b100 : 3'b001);
        chk("row19_bot", bot, 3'b010);
        if (rises > 0) chk("mclk_spacing", cyc - last_rise, 4);
      end
      if (exp_row == 5 && rises == 10 && coll_phase != 0)
        chk("coll_col10", top, (coll_phase == 1) ? 3'b000 : 3'b111);
      rises++;
      last_rise = cyc;
    end

    // Falling mclk marks phase cycle 0 of the next column: its read issues on
    // the coming edge, so a write now collides with it.
    if (!mclk && prev_mclk && exp_row == 5 && rises == 10 && n_fs == 1 && coll_phase == 0) begin
      wr_en = 1'b1;
      wr_addr = {5'd5, 5'd10};
      wr_data = 3'b111;
      coll_phase = 1;
    end

    if (chk_after) begin
      chk("oe_after_latch", output_en, 0);
      chk_after = 1'b0;
    end

    if (latch) begin
      chk("oe_at_latch", output_en, 1);
      chk("oe_before_latch", prev_oe, 1);
      chk("latch_row", row_sel, exp_row);
      if (n_latch > 0) chk("latch_period", cyc - last_latch, 258);
      else chk("first_latch_cyc", cyc, 130);
      if (exp_row == 3) chk("row3_edges", rises, 32);
      last_latch = cyc;
      n_latch++;
      exp_row = (exp_row + 1) % 16;
      rises = 0;
      chk_after = 1'b1;
    end

    if (latch_b) begin
      if (n_latch_b > 0) chk("latch_period_64", cyc - last_latch_b, 130);
      last_latch_b = cyc;
      n_latch_b++;
    end

    if (row_sel != prev_row_sel) chk("row_sel_on_latch", latch, 1);

    prev_mclk = mclk;
    prev_oe = output_en;
    prev_row_sel = row_sel;
  endtask

  initial begin
    coll_phase = 0;
    restart_counters();
    repeat (2) @(negedge clk);

    chk("rst_oe", output_en, 1);
    chk("rst_latch", latch, 0);
    chk("rst_mclk", mclk, 0);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rgb", {red_1, green_1, blue_1, red_2, green_2, blue_2}, 0);

    for (int c = 0; c < 32; c++) begin
      wr_pix({5'd3, 5'(c)}, (c % 2 == 0) ? 3'b100 : 3'b001);
      wr_pix({5'd19, 5'(c)}, 3'b010);
      wr_pix({5'd5, 5'(c)}, 3'b000);
    end

    release_reset();

    while (!(n_fs >= 3 && exp_row == 7 && rises == 5) && cyc < 12000) sample();
    chk("reached_row7", (cyc < 12000) ? 1 : 0, 1);
    chk("coll_seen", coll_phase, 2);
    chk("oe_lit", output_en, 0);

    reset_n = 1'b0;
    #1;
    chk("oe_async_reset", output_en, 1);
    chk("mclk_async_reset", mclk, 0);
    chk("latch_async_reset", latch, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_latch_in_reset", latch, 0);
      chk("oe_in_reset", output_en, 1);
    end

    release_reset();
    while (n_latch == 0 && cyc < 400) sample();
    chk("restart_latched", n_latch, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
